// File: rtl/restoring_mul_add.sv
// Sequential shift-add multiply-accumulate p = a*b + c, one multiplier bit per clock.
// Rebuilds a divider's dividend from its quotient, divisor and remainder.
module restoring_mul_add #(
  parameter int WA = 32,
  parameter int WB = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WA-1:0]    a,
  input  logic [WB-1:0]    b,
  input  logic [WB-1:0]    c,
  input  logic             start,
  output logic [WA+WB-1:0] p,
  output logic             busy,
  output logic             ready
);

  localparam int WP = WA + WB;
  localparam int WC = $clog2(WB + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [WP-1:0] r_a_sh;
  logic [WP-1:0] r_acc;
  logic [WB-1:0] r_b_sh;
  logic [WC-1:0] r_cnt;

  logic [WP-1:0] w_acc_next;
  logic          w_last;

  // The width rule guarantees the accumulator never wraps, so no carry-out is kept.
  assign w_acc_next = r_b_sh[0] ? (r_acc + r_a_sh) : r_acc;
  assign w_last     = (r_cnt == WC'(WB - 1));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_a_sh  <= '0;
      r_acc   <= '0;
      r_b_sh  <= '0;
      r_cnt   <= '0;
      p       <= '0;
      busy    <= 1'b0;
      ready   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_a_sh  <= {{WB{1'b0}}, a};
            r_b_sh  <= b;
            r_acc   <= {{WA{1'b0}}, c};
            r_cnt   <= '0;
            busy    <= 1'b1;
            ready   <= 1'b0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          // Fixed WB iterations: no early exit when the remaining multiplier bits are zero.
          r_acc  <= w_acc_next;
          r_a_sh <= r_a_sh << 1;
          r_b_sh <= r_b_sh >> 1;
          r_cnt  <= r_cnt + WC'(1);
          if (w_last) begin
            p       <= w_acc_next;
            busy    <= 1'b0;
            ready   <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          ready   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_mul_add.sv
// Directed bench for restoring_mul_add: latency, handshake, reset and divider round trip.
`timescale 1ns/1ps
module tb_restoring_mul_add;

  localparam int WA = 32;
  localparam int WB = 16;
  localparam int WP = WA + WB;

  logic          clk;
  logic          clr;
  logic [WA-1:0] a;
  logic [WB-1:0] b;
  logic [WB-1:0] c;
  logic          start;
  logic [WP-1:0] p;
  logic          busy;
  logic          ready;

  int total;
  int bad;

  restoring_mul_add #(.WA(WA), .WB(WB)) dut (
    .clk   (clk),
    .clr   (clr),
    .a     (a),
    .b     (b),
    .c     (c),
    .start (start),
    .p     (p),
    .busy  (busy),
    .ready (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [WP-1:0] obs, input logic [WP-1:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  // Accept, then verify busy for exactly WB-1 further edges, ready on edge WB.
  task automatic run_op(input string tag, input logic [WA-1:0] ta, input logic [WB-1:0] tb,
                        input logic [WB-1:0] tc, input logic [WP-1:0] exp_p,
                        input logic [WP-1:0] old_p);
    a = ta; b = tb; c = tc; start = 1'b1;
    tick();
    start = 1'b0;
    a = ~ta; b = ~tb; c = ~tc;
    check({tag, "_accept_bsy_rdy"}, WP'({busy, ready}), WP'(2'b10));
    check({tag, "_p_kept"}, p, old_p);
    for (int i = 1; i < WB; i++) begin
      tick();
      check($sformatf("%s_run%0d_bsy_rdy", tag, i), WP'({busy, ready}), WP'(2'b10));
    end
    tick();
    check({tag, "_done_bsy_rdy"}, WP'({busy, ready}), WP'(2'b01));
    check({tag, "_p"}, p, exp_p);
    $display("txn %s a=0x%0h b=0x%0h c=0x%0h p=0x%0h", tag, ta, tb, tc, p);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clr = 1'b1; a = '0; b = '0; c = '0; start = 1'b0;
    tick();
    tick();
    check("reset_p", p, '0);
    check("reset_bsy_rdy", WP'({busy, ready}), WP'(2'b00));
    clr = 1'b0;
    tick();
    check("idle_bsy_rdy", WP'({busy, ready}), WP'(2'b00));

    run_op("t1", 32'h0001_0000, 16'h0003, 16'h0002, 48'h0000_0003_0002, 48'h0);
    run_op("t2", 32'hFFFF_FFFF, 16'hFFFF, 16'hFFFF, 48'hFFFF_0000_0000, 48'h0000_0003_0002);
    run_op("t3", 32'h1234_5678, 16'h0000, 16'h00AB, 48'h0000_0000_00AB, 48'hFFFF_0000_0000);

    // ready and p hold in DONE while inputs wander and start stays low
    a = 32'hDEAD_BEEF; b = 16'h5555; c = 16'h1111;
    tick();
    tick();
    check("t3_hold_p", p, 48'h0000_0000_00AB);
    check("t3_hold_bsy_rdy", WP'({busy, ready}), WP'(2'b01));

    // t4: start re-pulsed with a=0 mid-run must be ignored
    a = 32'h1234_5678; b = 16'h0010; c = 16'h0000; start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_accept_bsy_rdy", WP'({busy, ready}), WP'(2'b10));
    for (int i = 1; i < WB; i++) begin
      if (i == 5) begin
        a = '0; b = 16'hFFFF; start = 1'b1;
      end
      tick();
      start = 1'b0;
      check($sformatf("t4_run%0d_bsy_rdy", i), WP'({busy, ready}), WP'(2'b10));
    end
    tick();
    check("t4_done_bsy_rdy", WP'({busy, ready}), WP'(2'b01));
    check("t4_p", p, 48'h0001_2345_6780);
    $display("txn t4 a=0x12345678 b=0x10 c=0x0 p=0x%0h", p);

    // t5: async clear in the middle of a run
    a = 32'h0000_00FF; b = 16'h00FF; c = 16'h0001; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 8; i++) tick();
    check("t5_pre_clr_busy", WP'(busy), WP'(1'b1));
    clr = 1'b1;
    #1;
    check("t5_clr_p", p, '0);
    check("t5_clr_bsy_rdy", WP'({busy, ready}), WP'(2'b00));
    tick();
    clr = 1'b0;
    check("t5_after_clr_bsy_rdy", WP'({busy, ready}), WP'(2'b00));
    run_op("t5", 32'h0000_0007, 16'h0006, 16'h0005, 48'h0000_0000_002F, 48'h0);

    // t6: divider round trip, 0x4C7F228A / 0x6A0E = 0xB8A6 rem 0x4D76
    run_op("t6", 32'h0000_B8A6, 16'h6A0E, 16'h4D76, 48'h0000_4C7F_228A, 48'h0000_0000_002F);
    a = 32'h0000_0003; b = 16'h0004; c = 16'h0005; start = 1'b1;
    tick();
    check("t6_b2b_bsy_rdy", WP'({busy, ready}), WP'(2'b10));
    check("t6_b2b_p_kept", p, 48'h0000_4C7F_228A);
    start = 1'b0;
    for (int i = 1; i < WB; i++) tick();
    check("t6_b2b_last_busy", WP'({busy, ready}), WP'(2'b10));
    tick();
    check("t6_b2b_done_bsy_rdy", WP'({busy, ready}), WP'(2'b01));
    check("t6_b2b_p", p, 48'h0000_0000_0011);
    $display("txn t6b a=0x3 b=0x4 c=0x5 p=0x%0h", p);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
